// File: rtl/nes_dma_pkg.sv
// Shared state encoding and fixed bus addresses for the OAM sprite DMA engine.
package nes_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: snoops CPU writes to $4014, halts the CPU and copies one page into OAMDATA.
// Define OAM_DMA_ALIGN_EN for cycle-accurate get/put alignment (513 or 514 halted cycles).
module oam_dma_controller
   import nes_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DATA_OUT,
   input  logic        CPU_wren,
   input  logic [7:0]  BUS_DATA_IN,
   output logic        CPU_RDY,
   output logic        DMA_ACTIVE,
   output logic [15:0] DMA_ADDR,
   output logic [7:0]  DMA_DATA_OUT,
   output logic        DMA_rden,
   output logic        DMA_wren
);

   localparam logic [7:0] LAST_COUNT = 8'(XFER_LEN - 1);

   dma_state_t state_q, state_d;
   logic [7:0] page_q,  page_d;
   logic [7:0] count_q, count_d;
   logic [7:0] data_q,  data_d;
   logic       trigger;

`ifdef OAM_DMA_ALIGN_EN
   logic parity_q, parity_d;

   assign parity_d = ~parity_q;
`endif

   assign trigger = CPU_wren && (CPU_ADDR == DMA_REG_ADDR);

   // Next-state logic; a trigger seen outside IDLE is deliberately dropped.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      count_d = count_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = HALT;
               page_d  = CPU_DATA_OUT;
               count_d = 8'd0;
            end
         end
         HALT: begin
            state_d = READ;
`ifdef OAM_DMA_ALIGN_EN
            // parity_q==0 here means the cycle after HALT is a put cycle.
            if (!parity_q) begin
               state_d = ALIGN;
            end
`endif
         end
         ALIGN: begin
            state_d = READ;
         end
         READ: begin
            data_d  = BUS_DATA_IN;
            state_d = WRITE;
         end
         WRITE: begin
            count_d = count_q + 8'd1;
            state_d = (count_q == LAST_COUNT) ? IDLE : READ;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         page_q   <= 8'd0;
         count_q  <= 8'd0;
         data_q   <= 8'd0;
`ifdef OAM_DMA_ALIGN_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         count_q  <= count_d;
         data_q   <= data_d;
`ifdef OAM_DMA_ALIGN_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs decode purely from the state flop, so reset forces them back asynchronously.
   always_comb begin
      CPU_RDY      = 1'b0;
      DMA_ACTIVE   = 1'b0;
      DMA_ADDR     = 16'h0000;
      DMA_rden     = 1'b0;
      DMA_wren     = 1'b0;
      DMA_DATA_OUT = data_q;
      unique case (state_q)
         IDLE: begin
            CPU_RDY = 1'b1;
         end
         READ: begin
            DMA_ACTIVE = 1'b1;
            DMA_rden   = 1'b1;
            DMA_ADDR   = {page_q, count_q};
         end
         WRITE: begin
            DMA_ACTIVE = 1'b1;
            DMA_wren   = 1'b1;
            DMA_ADDR   = OAM_DATA_ADDR;
         end
         default: begin
            CPU_RDY = 1'b0;
         end
      endcase
   end

   assert property (@(posedge CLK) disable iff (RESET) !(DMA_rden && DMA_wren));

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: bus memory model plus per-transfer scoreboard.
`timescale 1ns/1ps
module tb_oam_dma_controller;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA_OUT;
   logic        CPU_wren;
   logic [7:0]  BUS_DATA_IN;
   logic        CPU_RDY;
   logic        DMA_ACTIVE;
   logic [15:0] DMA_ADDR;
   logic [7:0]  DMA_DATA_OUT;
   logic        DMA_rden;
   logic        DMA_wren;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] mem [0:65535];
   logic       tb_parity;

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   oam_dma_controller dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .CPU_ADDR     (CPU_ADDR),
      .CPU_DATA_OUT (CPU_DATA_OUT),
      .CPU_wren     (CPU_wren),
      .BUS_DATA_IN  (BUS_DATA_IN),
      .CPU_RDY      (CPU_RDY),
      .DMA_ACTIVE   (DMA_ACTIVE),
      .DMA_ADDR     (DMA_ADDR),
      .DMA_DATA_OUT (DMA_DATA_OUT),
      .DMA_rden     (DMA_rden),
      .DMA_wren     (DMA_wren)
   );

   always #5 CLK = ~CLK;

   // Zero-wait bus: read data follows the DMA address combinationally.
   assign BUS_DATA_IN = mem[DMA_ADDR];

   // Get/put phase as defined by the bus: 0 after reset, toggling every clock.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) tb_parity <= 1'b0;
      else       tb_parity <= ~tb_parity;
   end

   task automatic fill_page(input logic [7:0] page, input bit inverted);
      for (int i = 0; i < 256; i++) begin
         mem[{page, i[7:0]}] = inverted ? ~i[7:0] : 8'($urandom);
      end
   endtask

   // Triggers one transfer and scores every halted cycle against the page contents.
   task automatic run_dma(input logic [7:0] page, input bit poke, input string tag);
      int          low_cycles = 0;
      int          quiet_cycles = 0;
      int          n_rd = 0;
      int          n_wr = 0;
      int          bad_rd = 0;
      int          bad_wr = 0;
      int          bad_excl = 0;
      bit          done = 1'b0;
      logic        halt_par = 1'b0;
      logic [15:0] last_rd = 16'h0000;
      logic [7:0]  exp_byte;
      int          exp_low;
      int          exp_quiet;

      @(posedge CLK); #1;
      CPU_ADDR     = 16'h4014;
      CPU_DATA_OUT = page;
      CPU_wren     = 1'b1;
      @(negedge CLK);
      compared++;
      if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0 || DMA_rden !== 1'b0 || DMA_wren !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s trigger_cycle_quiet: rdy=%b act=%b rd=%b wr=%b required 1/0/0/0",
                  tag, CPU_RDY, DMA_ACTIVE, DMA_rden, DMA_wren);
      end
      @(posedge CLK); #1;
      CPU_wren     = 1'b0;
      CPU_ADDR     = 16'($urandom_range(0, 16'h3FFF));
      CPU_DATA_OUT = 8'($urandom);

      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge CLK);
         if (cyc == 0) halt_par = tb_parity;
         if (poke && cyc == 51) CPU_wren = 1'b0;
         if (CPU_RDY === 1'b1) begin
            done = 1'b1;
            break;
         end
         low_cycles++;
         if (DMA_rden === 1'b1 && DMA_wren === 1'b1) bad_excl++;
         if (DMA_ACTIVE !== (DMA_rden | DMA_wren)) bad_excl++;
         if (DMA_rden !== 1'b1 && DMA_wren !== 1'b1) quiet_cycles++;
         if (DMA_rden === 1'b1) begin
            if (DMA_ADDR !== {page, n_rd[7:0]}) bad_rd++;
            last_rd = DMA_ADDR;
            n_rd++;
         end
         if (DMA_wren === 1'b1) begin
            exp_byte = mem[{page, n_wr[7:0]}];
            if (DMA_ADDR !== 16'h2004 || DMA_DATA_OUT !== exp_byte || n_wr != n_rd - 1) bad_wr++;
            n_wr++;
         end
         if (poke && cyc == 50) begin
            CPU_ADDR     = 16'h4014;
            CPU_DATA_OUT = ~page;
            CPU_wren     = 1'b1;
         end
      end
      CPU_wren = 1'b0;

      exp_quiet = (ALIGN_EN && !halt_par) ? 2 : 1;
      exp_low   = 512 + exp_quiet;

      compared++;
      if (!done) begin
         mismatched++;
         $display("[TB] FAIL %s completion: CPU_RDY never returned within 700 cycles, required return", tag);
      end
      compared++;
      if (low_cycles != exp_low) begin
         mismatched++;
         $display("[TB] FAIL %s rdy_low_cycles: got %0d required %0d", tag, low_cycles, exp_low);
      end
      compared++;
      if (quiet_cycles != exp_quiet) begin
         mismatched++;
         $display("[TB] FAIL %s strobeless_halt_cycles: got %0d required %0d", tag, quiet_cycles, exp_quiet);
      end
      compared++;
      if (n_rd != 256 || n_wr != 256) begin
         mismatched++;
         $display("[TB] FAIL %s transfer_count: reads %0d writes %0d required 256/256", tag, n_rd, n_wr);
      end
      compared++;
      if (bad_rd != 0) begin
         mismatched++;
         $display("[TB] FAIL %s read_addresses: %0d wrong required 0", tag, bad_rd);
      end
      compared++;
      if (bad_wr != 0) begin
         mismatched++;
         $display("[TB] FAIL %s oam_writes: %0d wrong required 0", tag, bad_wr);
      end
      compared++;
      if (bad_excl != 0) begin
         mismatched++;
         $display("[TB] FAIL %s strobe_exclusive: %0d violations required 0", tag, bad_excl);
      end
      compared++;
      if (last_rd !== {page, 8'hFF}) begin
         mismatched++;
         $display("[TB] FAIL %s last_read_addr: got %h required %h", tag, last_rd, {page, 8'hFF});
      end
      compared++;
      if (DMA_ACTIVE !== 1'b0 || DMA_rden !== 1'b0 || DMA_wren !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s release_quiet: act=%b rd=%b wr=%b required 0/0/0",
                  tag, DMA_ACTIVE, DMA_rden, DMA_wren);
      end
   endtask

   task automatic test_reset();
      RESET        = 1'b1;
      CPU_ADDR     = 16'h0000;
      CPU_DATA_OUT = 8'h00;
      CPU_wren     = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      compared++;
      if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0 || DMA_rden !== 1'b0 || DMA_wren !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_controls: rdy=%b act=%b rd=%b wr=%b required 1/0/0/0",
                  CPU_RDY, DMA_ACTIVE, DMA_rden, DMA_wren);
      end
      compared++;
      if (DMA_ADDR !== 16'h0000 || DMA_DATA_OUT !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_buses: addr=%h data=%h required 0000/00", DMA_ADDR, DMA_DATA_OUT);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      compared++;
      if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL post_reset_idle: rdy=%b act=%b required 1/0", CPU_RDY, DMA_ACTIVE);
      end
   endtask

   task automatic test_even_start();
      fill_page(8'h02, 1'b0);
      run_dma(8'h02, 1'b0, "even_start");
   endtask

   task automatic test_odd_start();
      @(posedge CLK);
      run_dma(8'h02, 1'b0, "odd_start");
   endtask

   task automatic test_data_integrity();
      fill_page(8'h02, 1'b1);
      run_dma(8'h02, 1'b0, "data_integrity");
   endtask

   task automatic test_reset_abort();
      int n_rd = 0;
      fill_page(8'h05, 1'b0);
      @(posedge CLK); #1;
      CPU_ADDR     = 16'h4014;
      CPU_DATA_OUT = 8'h05;
      CPU_wren     = 1'b1;
      @(posedge CLK); #1;
      CPU_wren = 1'b0;
      for (int cyc = 0; cyc < 400 && n_rd < 100; cyc++) begin
         @(negedge CLK);
         if (DMA_rden === 1'b1) n_rd++;
      end
      compared++;
      if (n_rd != 100) begin
         mismatched++;
         $display("[TB] FAIL abort_reach_read100: got %0d reads required 100", n_rd);
      end
      #1 RESET = 1'b1;
      #1;
      compared++;
      if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0 || DMA_rden !== 1'b0 || DMA_wren !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_async_controls: rdy=%b act=%b rd=%b wr=%b required 1/0/0/0",
                  CPU_RDY, DMA_ACTIVE, DMA_rden, DMA_wren);
      end
      compared++;
      if (DMA_ADDR !== 16'h0000 || DMA_DATA_OUT !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL abort_async_buses: addr=%h data=%h required 0000/00", DMA_ADDR, DMA_DATA_OUT);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;
      run_dma(8'h05, 1'b0, "after_abort");
   endtask

   task automatic test_non_trigger();
      logic [15:0] addrs [3];
      int          bad;
      addrs[0] = 16'h4015;
      addrs[1] = 16'h2004;
      addrs[2] = 16'h4013;
      for (int a = 0; a < 3; a++) begin
         bad = 0;
         @(posedge CLK); #1;
         CPU_ADDR     = addrs[a];
         CPU_DATA_OUT = 8'($urandom);
         CPU_wren     = 1'b1;
         @(posedge CLK); #1;
         CPU_wren = 1'b0;
         repeat (4) begin
            @(negedge CLK);
            if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) bad++;
         end
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL non_trigger_%h: %0d halted/active cycles required 0", addrs[a], bad);
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_page(8'h02, 1'b0);
      fill_page(8'h03, 1'b0);
      run_dma(8'h02, 1'b0, "b2b_first");
      run_dma(8'h03, 1'b0, "b2b_second");
   endtask

   task automatic test_random();
      logic [7:0] page;
      for (int t = 0; t < 4; t++) begin
         page = 8'($urandom);
         fill_page(page, 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         run_dma(page, (t == 1), "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      $display("[TB] oam_dma_controller bench start (align_en=%0d)", ALIGN_EN);
      test_reset();
      test_even_start();
      test_odd_start();
      test_data_integrity();
      test_reset_abort();
      test_non_trigger();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
